imem_arbiter: RTL
=================

# imem_arbiter

Single-port access controller for the 1024-word instruction memory. It shares the memory between three requesters: the instruction-fetch stage, the data-side read port used for loads from text space, and the program loader that writes test images. A two-state boot/run FSM sequences the memory: images are loaded first, then the CPU runs. A starvation counter guarantees fetch forward progress under data-read pressure.

## Interface
Parameters:
- AW, 10: word-address width; the memory holds 2^AW words.
- MAXWAIT, 3: number of consecutive denied fetch cycles after which fetch outranks the data port (≥1).

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- boot_done  in  1  loader has finished writing the image
- fetch_req  in  1  fetch read request; held until granted
- fetch_addr  in  AW  fetch word address
- fetch_gnt  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  fetch_rdata valid (one-cycle pulse)
- fetch_rdata  out  32  fetch read data
- dat_req  in  1  data-side read request; held until granted
- dat_addr  in  AW  data word address
- dat_gnt  out  1  data request accepted this cycle
- dat_rvalid  out  1  dat_rdata valid (one-cycle pulse)
- dat_rdata  out  32  data read data
- ld_req  in  1  loader write request; held until granted
- ld_addr  in  AW  loader word address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_err  out  1  pulses when a loader write was refused
- mem_addr  out  AW  memory word address
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_addr
- running  out  1  high in RUN state

## Operation
- FSM states:
  - BOOT (after reset): only the loader is served; fetch_gnt and dat_gnt stay 0.
  - RUN: only fetch and data reads are served.
- BOOT→RUN occurs on the edge where boot_done=1. A loader write granted in that same cycle is still performed. RUN is left only by reset.
- Grants are combinational from the req inputs, the state, and the starvation counter. At most one gnt is high per cycle.
- BOOT: ld_gnt = ld_req. When granted, mem_we=1, mem_addr=ld_addr, mem_wd=ld_wdata.
- RUN priority: dat over fetch, except when wait_cnt==MAXWAIT, in which case fetch wins.
- RUN, loader request: ld_req is granted only when neither read port is requesting. No write is performed (mem_we=0), and ld_err pulses high the next cycle.
- A granted read drives mem_addr from the winning port. mem_rd is registered into that port's rdata, and its rvalid pulses the following cycle. Each rdata holds its value until that port's next grant.
- When nothing is granted: mem_addr=0, mem_we=0, mem_wd=0.
- Starvation counter wait_cnt, width ceil(log2(MAXWAIT+1)), RUN only:
  - increments when fetch_req=1 and fetch_gnt=0
  - clears when fetch is granted or fetch_req=0
  - saturates at MAXWAIT
- Reset (any state, mid-transfer included) has these effects:
  - state=BOOT, wait_cnt=0
  - fetch_rvalid=dat_rvalid=ld_err=0, fetch_rdata=dat_rdata=0, running=0
  - all gnt and mem_we forced 0 during the reset cycle
  - any request granted in that cycle is dropped; no rvalid follows it

## Timing
- Grant latency: 0 cycles. gnt appears in the same cycle as req if that port wins.
- Read latency: rvalid/rdata appear 1 cycle after gnt.
- Throughput: one access per cycle.
- Write: a BOOT write takes effect at the gnt cycle edge. A read of the same address in a later cycle returns the new data.
- running rises 1 cycle after the boot_done edge. The first fetch grant is possible in that same cycle.
- Worst-case fetch wait in RUN under continuous dat_req: MAXWAIT denied cycles, then granted on cycle MAXWAIT+1. After that grant the counter restarts from 0.
- Requesters hold req and addr stable until gnt. Behaviour when req drops before gnt is defined: the request is simply not served.

## Test plan
- Boot load: in BOOT, write 0x2010_0005 @3 and 0xAC02_0044 @4; fetch_req held high meanwhile → fetch_gnt stays 0, mem_we pulses twice. Assert boot_done → running=1 next cycle; fetch @3 → fetch_rvalid next cycle with rdata 0x2010_0005.
- Priority/starvation (MAXWAIT=3): in RUN, hold dat_req and fetch_req continuously → dat granted 3 cycles, fetch granted on the 4th, then the pattern repeats (3 dat : 1 fetch).
- RUN loader refusal: ld_req with both read ports idle → ld_gnt=1, mem_we=0, ld_err pulses the next cycle, memory contents unchanged.
- Simultaneous boot_done and ld_req @7=0xDEAD_BEEF → write performed, running=1 next cycle, a later read of @7 returns 0xDEAD_BEEF.
- Reset mid-read: assert reset in a fetch gnt cycle → no fetch_rvalid follows, all outputs 0, state BOOT, fetch_gnt=0 until the next boot_done.
- Address extremes: write/read @0 and @2^AW−1 (1023) → correct data, no aliasing between the two.

Source files
------------

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory access controller: loader writes during BOOT,
// fetch/data reads during RUN, with a starvation counter protecting fetch.
module imem_arbiter #(
    parameter int AW      = 10,
    parameter int MAXWAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          boot_done,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [31:0]   fetch_rdata,
    input  logic          dat_req,
    input  logic [AW-1:0] dat_addr,
    output logic          dat_gnt,
    output logic          dat_rvalid,
    output logic [31:0]   dat_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic          ld_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd,
    output logic          running
);

    localparam int WW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          starved;

    assign starved = (wait_cnt == WW'(MAXWAIT));
    assign running = (state == RUN);

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fetch_gnt    = 1'b0;
        dat_gnt      = 1'b0;
        ld_gnt       = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wd       = '0;
        if (!reset) begin
            case (state)
                BOOT: begin
                    ld_gnt = ld_req;
                    if (ld_req) begin
                        mem_we   = 1'b1;
                        mem_addr = ld_addr;
                        mem_wd   = ld_wdata;
                    end
                    if (boot_done) state_nxt = RUN;
                end
                RUN: begin
                    // Data outranks fetch until fetch has waited MAXWAIT cycles.
                    if (fetch_req && (!dat_req || starved)) begin
                        fetch_gnt = 1'b1;
                        mem_addr  = fetch_addr;
                    end else if (dat_req) begin
                        dat_gnt  = 1'b1;
                        mem_addr = dat_addr;
                    end else begin
                        ld_gnt = ld_req;
                    end
                    if (!fetch_req || fetch_gnt) wait_cnt_nxt = '0;
                    else if (!starved)           wait_cnt_nxt = wait_cnt + 1'b1;
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Read data is captured only on that port's grant and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_rvalid <= 1'b0;
            dat_rvalid   <= 1'b0;
            ld_err       <= 1'b0;
            fetch_rdata  <= '0;
            dat_rdata    <= '0;
        end else begin
            fetch_rvalid <= fetch_gnt;
            dat_rvalid   <= dat_gnt;
            ld_err       <= ld_gnt && (state == RUN);
            if (fetch_gnt) fetch_rdata <= mem_rd;
            if (dat_gnt)   dat_rdata   <= mem_rd;
        end
    end

endmodule
